// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: operation mnemonics and FSM states.
package definitions;

  typedef enum logic [3:0] {
    kADD   = 4'd0,
    kSUB   = 4'd1,
    kAND   = 4'd2,
    kOR    = 4'd3,
    kSLL   = 4'd4,
    kSRL   = 4'd5,
    kSLT   = 4'd6,
    kSLTU  = 4'd7,
    kTWCMP = 4'd8,
    kABS   = 4'd9,
    kSLLV  = 4'd10,
    kSRLV  = 4'd11,
    kMUL   = 4'd12,
    kDIVU  = 4'd13
  } ALUOp_mne;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  function automatic logic is_iter(input logic [3:0] op);
    return (op == kMUL) || (op == kDIVU);
  endfunction

endpackage

// File: rtl/alu_mc_muldiv_iter.sv
// W-step unsigned shift-add multiplier / restoring divider with step counter.
module alu_muldiv_iter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic         is_div,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         last,
  output logic [W-1:0] step_lo,
  output logic [W-1:0] step_hi,
  output logic         step_ov
);
  localparam int CW = $clog2(W);

  logic [W:0]    acc_q, acc_d;
  logic [W-1:0]  mq_q, mq_d;
  logic [W-1:0]  opnd_q, opnd_d;
  logic          div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0]    sum, shifted, diff;

  // acc holds the running high half (MUL) or partial remainder (DIVU);
  // mq holds the multiplier being consumed or the dividend/quotient shift register.
  always_comb begin
    acc_d   = acc_q;
    mq_d    = mq_q;
    opnd_d  = opnd_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    sum     = acc_q + (mq_q[0] ? {1'b0, opnd_q} : '0);
    shifted = {acc_q[W-1:0], mq_q[W-1]};
    diff    = shifted - {1'b0, opnd_q};
    if (load) begin
      acc_d  = '0;
      mq_d   = a;
      opnd_d = b;
      div_d  = is_div;
      cnt_d  = CW'(W - 1);
    end else if (step) begin
      cnt_d = cnt_q - CW'(1);
      if (div_q) begin
        if (!diff[W]) begin
          acc_d = diff;
          mq_d  = {mq_q[W-2:0], 1'b1};
        end else begin
          acc_d = shifted;
          mq_d  = {mq_q[W-2:0], 1'b0};
        end
      end else begin
        acc_d = {1'b0, sum[W:1]};
        mq_d  = {sum[0], mq_q[W-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      mq_q   <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      mq_q   <= mq_d;
      opnd_q <= opnd_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
    end
  end

  // Outputs reflect the state after the current step so the final step can be captured directly.
  assign last    = (cnt_q == '0);
  assign step_lo = mq_d;
  assign step_hi = acc_d[W-1:0];
  assign step_ov = div_q ? (opnd_q == '0) : (acc_d[W-1:0] != '0);

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle op set plus iterative MUL/DIVU behind a Start/Busy/Done handshake.
module alu_mc
  import definitions::*;
#(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         Start,
  input  logic [3:0]   ALUOp,
  input  logic [W-1:0] SrcA,
  input  logic [W-1:0] SrcB,
  output logic         Busy,
  output logic         Done,
  output logic [W-1:0] Result,
  output logic [W-1:0] ResultHi,
  output logic         OvOut
);
  localparam int SW = $clog2(W);

  alu_state_e   state_q, state_d;
  logic [W-1:0] res_q, res_d, hi_q, hi_d;
  logic         ov_q, ov_d;
  logic         load, step;
  logic         it_last, it_ov;
  logic [W-1:0] it_lo, it_hi;

  logic [W-1:0] sc_res, sub_diff, neg_a;
  logic         sc_ov, a_min;
  logic [W:0]   add_sum;
  logic [SW-1:0] sh;

  alu_muldiv_iter #(.W(W)) u_iter (
    .clk     (CLK),
    .rst     (Reset),
    .load    (load),
    .step    (step),
    .is_div  (ALUOp == kDIVU),
    .a       (SrcA),
    .b       (SrcB),
    .last    (it_last),
    .step_lo (it_lo),
    .step_hi (it_hi),
    .step_ov (it_ov)
  );

  always_comb begin
    add_sum  = {1'b0, SrcA} + {1'b0, SrcB};
    sub_diff = SrcA - SrcB;
    neg_a    = ~SrcA + W'(1);
    a_min    = (SrcA == {1'b1, {(W-1){1'b0}}});
    sh       = SrcB[SW-1:0];
    sc_res   = '0;
    sc_ov    = 1'b0;
    case (ALUOp)
      kADD:   begin sc_res = add_sum[W-1:0]; sc_ov = add_sum[W]; end
      kSUB:   begin
        sc_res = sub_diff;
        sc_ov  = (SrcA[W-1] != SrcB[W-1]) && (sub_diff[W-1] != SrcA[W-1]);
      end
      kAND:   sc_res = SrcA & SrcB;
      kOR:    sc_res = SrcA | SrcB;
      kSLL:   begin sc_res = {SrcA[W-2:0], 1'b0}; sc_ov = SrcA[W-1]; end
      kSRL:   begin sc_res = {1'b0, SrcA[W-1:1]}; sc_ov = SrcA[0]; end
      kSLT:   sc_ov = $signed(SrcA) < $signed(SrcB);
      kSLTU:  sc_ov = SrcA < SrcB;
      kTWCMP: begin sc_res = neg_a; sc_ov = a_min; end
      // Negating the most-negative value wraps back to itself, giving Result = A.
      kABS:   begin sc_res = SrcA[W-1] ? neg_a : SrcA; sc_ov = a_min; end
      kSLLV:  sc_res = SrcA << sh;
      kSRLV:  sc_res = SrcA >> sh;
      default: begin sc_res = '0; sc_ov = 1'b0; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    hi_d    = hi_q;
    ov_d    = ov_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (Start) begin
          if (is_iter(ALUOp)) begin
            load    = 1'b1;
            state_d = RUN;
          end else begin
            state_d = DONE;
            res_d   = sc_res;
            hi_d    = '0;
            ov_d    = sc_ov;
          end
        end
      end
      RUN: begin
        step = 1'b1;
        if (it_last) begin
          state_d = DONE;
          res_d   = it_lo;
          hi_d    = it_hi;
          ov_d    = it_ov;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      res_q   <= '0;
      hi_q    <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      ov_q    <= ov_d;
    end
  end

  assign Busy     = (state_q == RUN);
  assign Done     = (state_q == DONE);
  assign Result   = res_q;
  assign ResultHi = hi_q;
  assign OvOut    = ov_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: arithmetic reference model, randomized and directed stimulus.
module tb_alu_mc;
  import definitions::*;

  localparam int W   = 8;
  localparam int SHM = 1 << $clog2(W);

  logic         CLK = 1'b0;
  logic         Reset, Start;
  logic [3:0]   ALUOp;
  logic [W-1:0] SrcA, SrcB, Result, ResultHi;
  logic         Busy, Done, OvOut;

  alu_mc #(.W(W)) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .Start    (Start),
    .ALUOp    (ALUOp),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .Busy     (Busy),
    .Done     (Done),
    .Result   (Result),
    .ResultHi (ResultHi),
    .OvOut    (OvOut)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         ov;
    int           due;
  } exp_t;

  exp_t         sb[$];
  int           tests = 0, fails = 0;
  int           ncyc = 0, free_at = 0, busy_lo = 1, busy_hi = 0;
  bit           mon_en = 1'b0;
  logic [W-1:0] last_res = '0, last_hi = '0;
  logic         last_ov = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, ncyc);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint ua = longint'(a), ub = longint'(b);
    longint half = longint'(1) << (W - 1);
    longint full = longint'(1) << W;
    longint sa = (ua >= half) ? ua - full : ua;
    longint sb_ = (ub >= half) ? ub - full : ub;
    longint r = 0, h = 0, d;
    bit     ov = 1'b0;
    case (op)
      kADD:   begin r = ua + ub; ov = (r >= full); end
      kSUB:   begin d = sa - sb_; r = ua - ub; ov = (d < -half) || (d > half - 1); end
      kAND:   r = ua & ub;
      kOR:    r = ua | ub;
      kSLL:   begin r = ua * 2; ov = (ua >= half); end
      kSRL:   begin r = ua / 2; ov = (ua % 2) == 1; end
      kSLT:   ov = (sa < sb_);
      kSLTU:  ov = (ua < ub);
      kTWCMP: begin r = -ua; ov = (ua == half); end
      kABS:   begin r = (sa < 0) ? -sa : sa; ov = (ua == half); end
      kSLLV:  r = ua << (ub % SHM);
      kSRLV:  r = ua >> (ub % SHM);
      kMUL:   begin r = ua * ub; h = (ua * ub) / full; ov = (h != 0); end
      kDIVU:  begin
        if (ub == 0) begin r = full - 1; h = ua; ov = 1'b1; end
        else begin r = ua / ub; h = ua % ub; end
      end
      default: begin r = 0; h = 0; ov = 1'b0; end
    endcase
    e.res = W'(r);
    e.hi  = W'(h);
    e.ov  = ov;
    e.due = 0;
    return e;
  endfunction

  always @(negedge CLK) begin
    exp_t e;
    bit   exp_done;
    ncyc++;
    if (mon_en) begin
      chk("busy", {63'd0, Busy}, {63'd0, (ncyc >= busy_lo) && (ncyc <= busy_hi)});
      exp_done = (sb.size() != 0) && (sb[0].due == ncyc);
      chk("done", {63'd0, Done}, {63'd0, exp_done});
      if (Done === 1'b1) begin
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("result", 64'(Result), 64'(e.res));
          chk("result_hi", 64'(ResultHi), 64'(e.hi));
          chk("ovout", {63'd0, OvOut}, {63'd0, e.ov});
          last_res = e.res;
          last_hi  = e.hi;
          last_ov  = e.ov;
        end
      end else begin
        chk("hold_result", 64'(Result), 64'(last_res));
        chk("hold_result_hi", 64'(ResultHi), 64'(last_hi));
        chk("hold_ovout", {63'd0, OvOut}, {63'd0, last_ov});
        if (sb.size() != 0 && sb[0].due <= ncyc) void'(sb.pop_front());
      end
    end
  end

  task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    @(negedge CLK); #1;
    Start = 1'b1;
    ALUOp = op;
    SrcA  = a;
    SrcB  = b;
    if (ncyc >= free_at) begin
      e     = model(op, a, b);
      e.due = ncyc + (((op == kMUL) || (op == kDIVU)) ? W + 1 : 1);
      sb.push_back(e);
      free_at = e.due;
      if ((op == kMUL) || (op == kDIVU)) begin
        busy_lo = ncyc + 1;
        busy_hi = ncyc + W;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK); #1;
      Start = 1'b0;
      ALUOp = 4'($urandom);
      SrcA  = W'($urandom);
      SrcB  = W'($urandom);
    end
  endtask

  task automatic wait_free();
    int k;
    k = free_at - ncyc - 1;
    if (k > 0) idle(k);
  endtask

  task automatic reset_mid();
    @(negedge CLK); #1;
    Reset = 1'b1;
    Start = 1'b1;
    ALUOp = kADD;
    sb.delete();
    busy_hi  = 0;
    free_at  = 0;
    last_res = '0;
    last_hi  = '0;
    last_ov  = 1'b0;
    @(negedge CLK); #1;
    Reset = 1'b0;
    Start = 1'b0;
    chk("rst_mid_busy", {63'd0, Busy}, 64'd0);
    chk("rst_mid_done", {63'd0, Done}, 64'd0);
    chk("rst_mid_result", 64'(Result), 64'd0);
    chk("rst_mid_result_hi", 64'(ResultHi), 64'd0);
    chk("rst_mid_ovout", {63'd0, OvOut}, 64'd0);
  endtask

  initial begin
    logic [3:0]   op;
    logic [W-1:0] a, b;
    Reset = 1'b1;
    Start = 1'b1;
    ALUOp = kADD;
    SrcA  = W'(1);
    SrcB  = W'(2);
    repeat (3) @(negedge CLK);
    #1;
    Reset  = 1'b0;
    Start  = 1'b0;
    mon_en = 1'b1;
    @(negedge CLK); #1;
    chk("reset_busy", {63'd0, Busy}, 64'd0);
    chk("reset_done", {63'd0, Done}, 64'd0);
    chk("reset_result", 64'(Result), 64'd0);
    chk("reset_result_hi", 64'(ResultHi), 64'd0);
    chk("reset_ovout", {63'd0, OvOut}, 64'd0);

    wait_free(); drive(kADD,   W'(200),  W'(100));
    wait_free(); drive(kSUB,   W'(100),  W'(8'h9C));
    wait_free(); drive(kMUL,   W'(25),   W'(13));
    wait_free(); drive(kMUL,   W'(15),   W'(15));
    wait_free(); drive(kDIVU,  W'(200),  W'(7));
    wait_free(); drive(kDIVU,  W'(55),   W'(0));
    wait_free(); drive(kABS,   W'(8'h80), W'(0));
    wait_free(); drive(kTWCMP, W'(5),    W'(0));
    wait_free(); drive(kSLLV,  W'(8'h81), W'(3));
    wait_free(); drive(4'hF,   W'(8'hAA), W'(8'h55));
    idle(2);

    // Start on every busy cycle must be ignored, then a Start in the DONE cycle is taken.
    wait_free(); drive(kMUL, W'(25), W'(13));
    repeat (W) drive(4'($urandom), W'($urandom), W'($urandom));
    drive(kADD,  W'(8'hF0), W'(8'h20));
    drive(kDIVU, W'(250),   W'(9));
    wait_free();
    drive(kSLT,  W'(8'hFE), W'(1));
    drive(kSLTU, W'(8'hFE), W'(1));
    drive(kSRL,  W'(8'h81), W'(0));
    drive(kSRLV, W'(8'h81), W'(9));
    idle(2);

    wait_free(); drive(kMUL, W'(200), W'(200));
    idle(3);
    reset_mid();
    idle(W + 3);

    repeat (200) begin
      op = 4'($urandom_range(0, 15));
      a  = W'($urandom);
      b  = W'($urandom);
      if ($urandom_range(0, 5) == 0) a = {1'b1, {(W-1){1'b0}}};
      if ((op == kDIVU) && ($urandom_range(0, 4) == 0)) b = '0;
      if ($urandom_range(0, 3) != 0) wait_free();
      drive(op, a, b);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    idle(W + 4);
    chk("drain", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
